// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Desc     : RV32I decode stage feeding a one-entry ID/EX register, with a
//            per-register scoreboard that stalls on RAW/WAW hazards.
//            Optional macro ID_WB_FORWARD_EN bypasses same-cycle writebacks.
// Revision : 1.0
// ============================================================================
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module id_stage #(
    parameter int WORD_WIDTH     = `WORD_WIDTH,
    parameter int REG_ADDR_WIDTH = `REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_instr,
    input  logic [WORD_WIDTH-1:0]     in_pc,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [WORD_WIDTH-1:0]     rs1_val,
    input  logic [WORD_WIDTH-1:0]     rs2_val,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [WORD_WIDTH-1:0]     wb_val,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_WIDTH-1:0]     out_pc,
    output logic [WORD_WIDTH-1:0]     out_rs1_val,
    output logic [WORD_WIDTH-1:0]     out_rs2_val,
    output logic [WORD_WIDTH-1:0]     out_imm,
    output logic [REG_ADDR_WIDTH-1:0] out_rd_addr,
    output logic                      out_rd_we,
    output logic [6:0]                out_opcode,
    output logic [2:0]                out_funct3,
    output logic                      out_funct7b5,
    output logic                      out_illegal
);
    localparam int         c_NREGS   = 1 << REG_ADDR_WIDTH;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_IMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD = 7'b0000011;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_S    = 7'b0100011;
    localparam logic [6:0] c_OP_B    = 7'b1100011;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;
    localparam logic [6:0] c_OP_AUI  = 7'b0010111;
    localparam logic [6:0] c_OP_J    = 7'b1101111;

    typedef struct packed {
        logic [WORD_WIDTH-1:0]     pc;
        logic [WORD_WIDTH-1:0]     rs1_val;
        logic [WORD_WIDTH-1:0]     rs2_val;
        logic [WORD_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rd_addr;
        logic                      rd_we;
        logic [6:0]                opcode;
        logic [2:0]                funct3;
        logic                      funct7b5;
        logic                      illegal;
    } idex_t;

    idex_t                idex_q, idex_d;
    logic                 out_valid_q, out_valid_d;
    logic [c_NREGS-1:0]   sb_q, sb_d;

    logic [6:0]                w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_rd, w_rs1, w_rs2;
    logic w_is_r, w_is_i, w_is_s, w_is_b, w_is_u, w_is_j;
    logic w_uses_rs1, w_uses_rs2, w_rd_we, w_illegal;
    logic [31:0]               w_imm32;
    logic [WORD_WIDTH-1:0]     w_imm, w_rs1_op, w_rs2_op;
    logic w_out_wr, w_rs1_sb, w_rs2_sb, w_rs1_hz, w_rs2_hz, w_waw_hz, w_hazard;
    logic w_accept, w_issue;

    assign w_opcode = in_instr[6:0];
    assign w_rd     = REG_ADDR_WIDTH'(in_instr[11:7]);
    assign w_rs1    = REG_ADDR_WIDTH'(in_instr[19:15]);
    assign w_rs2    = REG_ADDR_WIDTH'(in_instr[24:20]);
    assign rs1_addr = w_rs1;
    assign rs2_addr = w_rs2;

    always_comb begin
        w_is_r = 1'b0;
        w_is_i = 1'b0;
        w_is_s = 1'b0;
        w_is_b = 1'b0;
        w_is_u = 1'b0;
        w_is_j = 1'b0;
        case (w_opcode)
            c_OP_R:                          w_is_r = 1'b1;
            c_OP_IMM, c_OP_LOAD, c_OP_JALR:  w_is_i = 1'b1;
            c_OP_S:                          w_is_s = 1'b1;
            c_OP_B:                          w_is_b = 1'b1;
            c_OP_LUI, c_OP_AUI:              w_is_u = 1'b1;
            c_OP_J:                          w_is_j = 1'b1;
            default: ;
        endcase
    end

    assign w_uses_rs1 = w_is_r | w_is_i | w_is_s | w_is_b;
    assign w_uses_rs2 = w_is_r | w_is_s | w_is_b;
    assign w_rd_we    = (w_is_r | w_is_i | w_is_u | w_is_j) && (w_rd != '0);
    assign w_illegal  = !(w_is_r | w_is_i | w_is_s | w_is_b | w_is_u | w_is_j);

    always_comb begin
        w_imm32 = 32'd0;
        if (w_is_i)
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (w_is_s)
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (w_is_b)
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
        else if (w_is_u)
            w_imm32 = {in_instr[31:12], 12'd0};
        else if (w_is_j)
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
    end

    generate
        if (WORD_WIDTH > 32) begin : g_imm_wide
            assign w_imm = {{(WORD_WIDTH-32){w_imm32[31]}}, w_imm32};
        end else begin : g_imm_narrow
            assign w_imm = w_imm32[WORD_WIDTH-1:0];
        end
    endgenerate

    // A valid writer still sitting in the output register owns its rd too.
    assign w_out_wr = out_valid_q && idex_q.rd_we;

`ifdef ID_WB_FORWARD_EN
    logic w_rs1_fwd, w_rs2_fwd;
    assign w_rs1_fwd = wb_en && (wb_addr == w_rs1) && (w_rs1 != '0);
    assign w_rs2_fwd = wb_en && (wb_addr == w_rs2) && (w_rs2 != '0);
    assign w_rs1_sb  = sb_q[w_rs1] && !w_rs1_fwd;
    assign w_rs2_sb  = sb_q[w_rs2] && !w_rs2_fwd;
    assign w_rs1_op  = w_rs1_fwd ? wb_val : rs1_val;
    assign w_rs2_op  = w_rs2_fwd ? wb_val : rs2_val;
`else
    logic w_unused_wb;
    assign w_unused_wb = ^wb_val;
    assign w_rs1_sb    = sb_q[w_rs1];
    assign w_rs2_sb    = sb_q[w_rs2];
    assign w_rs1_op    = rs1_val;
    assign w_rs2_op    = rs2_val;
`endif

    assign w_rs1_hz = w_uses_rs1 && (w_rs1 != '0) &&
                      (w_rs1_sb || (w_out_wr && idex_q.rd_addr == w_rs1));
    assign w_rs2_hz = w_uses_rs2 && (w_rs2 != '0) &&
                      (w_rs2_sb || (w_out_wr && idex_q.rd_addr == w_rs2));
    assign w_waw_hz = w_rd_we && (sb_q[w_rd] || (w_out_wr && idex_q.rd_addr == w_rd));
    assign w_hazard = w_rs1_hz || w_rs2_hz || w_waw_hz;

    assign in_ready = !rst && !flush && (!out_valid_q || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;
    assign w_issue  = out_valid_q && out_ready && !flush;

    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        sb_d        = sb_q;
        if (w_accept) begin
            idex_d.pc       = in_pc;
            idex_d.rs1_val  = w_rs1_op;
            idex_d.rs2_val  = w_rs2_op;
            idex_d.imm      = w_imm;
            idex_d.rd_addr  = w_rd;
            idex_d.rd_we    = w_rd_we;
            idex_d.opcode   = w_opcode;
            idex_d.funct3   = in_instr[14:12];
            idex_d.funct7b5 = in_instr[30];
            idex_d.illegal  = w_illegal;
            out_valid_d     = 1'b1;
        end else if (flush || w_issue) begin
            out_valid_d = 1'b0;
        end
        // Clear before set: a same-cycle set belongs to the newer writer.
        if (wb_en && wb_addr != '0)
            sb_d[wb_addr] = 1'b0;
        if (w_issue && idex_q.rd_we)
            sb_d[idex_q.rd_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            out_valid_q <= 1'b0;
            sb_q        <= '0;
        end else begin
            idex_q      <= idex_d;
            out_valid_q <= out_valid_d;
            sb_q        <= sb_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_pc       = idex_q.pc;
    assign out_rs1_val  = idex_q.rs1_val;
    assign out_rs2_val  = idex_q.rs2_val;
    assign out_imm      = idex_q.imm;
    assign out_rd_addr  = idex_q.rd_addr;
    assign out_rd_we    = idex_q.rd_we;
    assign out_opcode   = idex_q.opcode;
    assign out_funct3   = idex_q.funct3;
    assign out_funct7b5 = idex_q.funct7b5;
    assign out_illegal  = idex_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Desc     : Directed and randomized bench for id_stage against a behavioural
//            decode/scoreboard model with a register-file and writeback model.
// Revision : 1.0
// ============================================================================
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, wb_en, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rs1_val, rs2_val, wb_val;
    logic [4:0]  rs1_addr, rs2_addr, wb_addr, out_rd_addr;
    logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
    logic        out_rd_we, out_funct7b5, out_illegal;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;

    always #5 clk = ~clk;

    id_stage #(.WORD_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_val(wb_val), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
        .out_illegal(out_illegal)
    );

    // Register file seen by the stage; written one edge after wb_en.
    logic [31:0] regs [32];
    assign rs1_val = (in_instr[19:15] == 5'd0) ? 32'd0 : regs[in_instr[19:15]];
    assign rs2_val = (in_instr[24:20] == 5'd0) ? 32'd0 : regs[in_instr[24:20]];

    typedef struct packed {
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rd;
        logic        we;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7b5, ill, u1, u2;
    } dec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
        int          due;
    } wb_t;

    dec_t        m_out;
    logic        m_valid;
    logic [31:0] pend;
    wb_t         wbq[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic        seen_ready;
    logic        auto_wb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        logic [11:0] i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_lui(input int rd, input logic [19:0] imm);
        return {imm, 5'(rd), 7'b0110111};
    endfunction

    // Immediates rebuilt as weighted field sums, then folded to signed range.
    function automatic dec_t decode(input logic [31:0] ins, input logic [31:0] pc);
        dec_t d;
        int   v;
        logic wr;
        d = '0; v = 0; wr = 1'b0;
        d.pc = pc; d.op = ins[6:0]; d.f3 = ins[14:12]; d.f7b5 = ins[30]; d.rd = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin d.u1 = 1; d.u2 = 1; wr = 1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin
                d.u1 = 1; wr = 1; v = int'(ins[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'b0100011: begin
                d.u1 = 1; d.u2 = 1; v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'b1100011: begin
                d.u1 = 1; d.u2 = 1;
                v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'b0110111, 7'b0010111: begin wr = 1; v = int'(ins[31:12]) * 4096; end
            7'b1101111: begin
                wr = 1;
                v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            default: d.ill = 1;
        endcase
        d.imm = 32'(v);
        d.we  = wr && (d.rd != 5'd0);
        return d;
    endfunction

    function automatic logic owned_by_out(input logic [4:0] r);
        return m_valid && m_out.we && (m_out.rd == r);
    endfunction

    function automatic logic src_blocked(input logic used, input logic [4:0] r);
        logic sb = pend[r];
`ifdef ID_WB_FORWARD_EN
        if (wb_en && wb_addr == r) sb = 1'b0;
`endif
        return used && (r != 5'd0) && (sb || owned_by_out(r));
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ID_WB_FORWARD_EN
        if (wb_en && wb_addr == r) return wb_val;
`endif
        return regs[r];
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        dec_t d;
        logic exp_rdy, acc, iss;
        wb_t  e;
        if (auto_wb) begin
            if (!rst && wbq.size() > 0 && wbq[0].due <= cyc) begin
                wb_en = 1'b1; wb_addr = wbq[0].rd; wb_val = wbq[0].val;
                void'(wbq.pop_front());
            end else begin
                wb_en = 1'b0; wb_addr = 5'($urandom()); wb_val = $urandom();
            end
        end
        #1;
        d = decode(in_instr, in_pc);
        exp_rdy = !rst && !flush && (!m_valid || out_ready) &&
                  !src_blocked(d.u1, in_instr[19:15]) && !src_blocked(d.u2, in_instr[24:20]) &&
                  !(d.we && (pend[d.rd] || owned_by_out(d.rd)));
        seen_ready = in_ready;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("rs1_addr", {27'd0, rs1_addr}, {27'd0, in_instr[19:15]});
        chk("rs2_addr", {27'd0, rs2_addr}, {27'd0, in_instr[24:20]});
        acc = in_valid && exp_rdy;
        iss = m_valid && out_ready && !flush;
        if (rst) begin
            m_valid = 1'b0; m_out = '0; pend = '0; wbq.delete();
        end else begin
            if (wb_en && wb_addr != 5'd0) pend[wb_addr] = 1'b0;
            if (iss && m_out.we) begin
                pend[m_out.rd] = 1'b1;
                e.rd = m_out.rd; e.val = $urandom(); e.due = cyc + int'($urandom_range(1, 6));
                wbq.push_back(e);
            end
            if (acc) begin
                m_out = d;
                m_out.rs1v = operand(in_instr[19:15]);
                m_out.rs2v = operand(in_instr[24:20]);
                m_valid = 1'b1;
            end else if (flush || iss) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (wb_en && wb_addr != 5'd0) regs[wb_addr] = wb_val;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("out_pc", out_pc, m_out.pc);
            chk("out_imm", out_imm, m_out.imm);
            chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, m_out.rd});
            chk("out_rd_we", {31'd0, out_rd_we}, {31'd0, m_out.we});
            chk("out_opcode", {25'd0, out_opcode}, {25'd0, m_out.op});
            chk("out_funct3", {29'd0, out_funct3}, {29'd0, m_out.f3});
            chk("out_funct7b5", {31'd0, out_funct7b5}, {31'd0, m_out.f7b5});
            chk("out_illegal", {31'd0, out_illegal}, {31'd0, m_out.ill});
            if (m_out.u1) chk("out_rs1_val", out_rs1_val, m_out.rs1v);
            if (m_out.u2) chk("out_rs2_val", out_rs2_val, m_out.rs2v);
        end
    endtask

    task automatic wb_cycle(input int r, input logic [31:0] v);
        wb_en = 1'b1; wb_addr = 5'(r); wb_val = v;
        cycle();
        wb_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom();
        logic [31:0] rop = $urandom();
        logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
        int k = int'($urandom_range(0, 9));
        ins[6:0]   = (k == 9) ? rop[6:0] : ops[k];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        m_valid = 1'b0; m_out = '0; pend = '0;
        rst = 1'b1; in_valid = 1'b1; in_instr = enc_addi(1, 0, 5); in_pc = 32'h100;
        out_ready = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = 5'd0; wb_val = 32'd0;

        cycle(); chk("rst_in_ready", {31'd0, seen_ready}, 32'd0);
        cycle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_imm", out_imm, 32'd0);
        chk("rst_out_rd_we", {31'd0, out_rd_we}, 32'd0);

        // straight-line issue
        rst = 1'b0;
        cycle();
        chk("s1_ready", {31'd0, seen_ready}, 32'd1);
        chk("s1_imm", out_imm, 32'd5);
        chk("s1_rd", {27'd0, out_rd_addr}, 32'd1);
        in_pc = 32'h104; in_instr = enc_addi(2, 0, 7);
        cycle();
        chk("s2_ready", {31'd0, seen_ready}, 32'd1);
        chk("s2_imm", out_imm, 32'd7);
        chk("s2_rd", {27'd0, out_rd_addr}, 32'd2);

        // RAW stall on x1
        in_pc = 32'h108; in_instr = enc_add(3, 1, 1);
        cycle(); chk("raw_stall0", {31'd0, seen_ready}, 32'd0);
        cycle(); chk("raw_stall1", {31'd0, seen_ready}, 32'd0);
        wb_cycle(1, 32'd5);
`ifdef ID_WB_FORWARD_EN
        chk("raw_fwd_ready", {31'd0, seen_ready}, 32'd1);
        in_valid = 1'b0;
`else
        chk("raw_wb_ready", {31'd0, seen_ready}, 32'd0);
        cycle(); chk("raw_ready", {31'd0, seen_ready}, 32'd1);
        in_valid = 1'b0;
`endif
        chk("raw_rs1", out_rs1_val, 32'd5);
        chk("raw_rs2", out_rs2_val, 32'd5);
        chk("raw_rd", {27'd0, out_rd_addr}, 32'd3);
        wb_cycle(2, 32'd7);
        wb_cycle(3, 32'd10);

        // x0 handling
        in_valid = 1'b1; in_instr = enc_add(5, 0, 0);
        cycle();
        chk("x0_ready", {31'd0, seen_ready}, 32'd1);
        chk("x0_add_we", {31'd0, out_rd_we}, 32'd1);
        in_instr = enc_addi(0, 0, 1);
        cycle();
        chk("x0w_ready", {31'd0, seen_ready}, 32'd1);
        chk("x0w_we", {31'd0, out_rd_we}, 32'd0);
        chk("x0w_imm", out_imm, 32'd1);
        in_valid = 1'b0;
        cycle();
        wb_cycle(5, 32'd0);

        // backpressure
        out_ready = 1'b0; in_valid = 1'b1; in_instr = enc_addi(8, 0, 3);
        cycle(); chk("bp_acc", {31'd0, seen_ready}, 32'd1);
        in_instr = enc_addi(9, 0, 4);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_stall", {31'd0, seen_ready}, 32'd0);
            chk("bp_hold", out_imm, 32'd3);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_ready", {31'd0, seen_ready}, 32'd1);
        chk("bp_next", out_imm, 32'd4);
        in_valid = 1'b0;
        cycle();
        wb_cycle(8, 32'd3);
        wb_cycle(9, 32'd4);

        // flush discards lui x4 without marking it pending
        in_valid = 1'b1; in_instr = enc_lui(4, 20'h12345);
        cycle();
        chk("fl_imm", out_imm, 32'h12345000);
        chk("fl_valid1", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; in_instr = enc_add(6, 4, 0);
        cycle();
        chk("fl_ready", {31'd0, seen_ready}, 32'd0);
        chk("fl_valid0", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        cycle();
        chk("fl_acc", {31'd0, seen_ready}, 32'd1);
        chk("fl_rd", {27'd0, out_rd_addr}, 32'd6);
        in_valid = 1'b0;
        cycle();
        wb_cycle(6, 32'd0);

        // set/clear collision on x7
        in_valid = 1'b1; in_instr = enc_addi(7, 0, 9);
        cycle();
        in_valid = 1'b0;
        wb_cycle(7, 32'd1);
        in_valid = 1'b1; in_instr = enc_add(10, 7, 0);
        cycle(); chk("col_stall0", {31'd0, seen_ready}, 32'd0);
        cycle(); chk("col_stall1", {31'd0, seen_ready}, 32'd0);
        wb_cycle(7, 32'd9);
`ifdef ID_WB_FORWARD_EN
        chk("col_fwd_ready", {31'd0, seen_ready}, 32'd1);
        in_valid = 1'b0;
`else
        chk("col_wb_ready", {31'd0, seen_ready}, 32'd0);
        cycle(); chk("col_ready", {31'd0, seen_ready}, 32'd1);
        in_valid = 1'b0;
`endif
        chk("col_rs1", out_rs1_val, 32'd9);
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // randomized traffic with a mid-run reset
        auto_wb = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst       = (n >= 1500 && n < 1502);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rand_instr();
            in_pc     = $urandom();
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction-decode stage sitting directly upstream of `reg_file`. Accepts fetched instructions over a valid/ready handshake, drives the register file's asynchronous read addresses, and decodes the immediate and control fields. Captures operands into a one-entry ID/EX output register. A per-register scoreboard stalls issue on RAW and WAW hazards until the matching writeback, which arrives on the same signals that drive `reg_file`'s write port.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (32): datapath width.
- `REG_ADDR_WIDTH`, default `` `REG_ADDR_WIDTH `` (5): register address width; scoreboard has `1<<REG_ADDR_WIDTH` bits.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: RV32I instruction word.
- `in_pc` in WORD_WIDTH: instruction PC.
- `rs1_addr`, `rs2_addr` out REG_ADDR_WIDTH: to `reg_file`; combinationally `in_instr[19:15]` and `in_instr[24:20]`.
- `rs1_val`, `rs2_val` in WORD_WIDTH: from `reg_file`, same cycle.
- `wb_en` in 1, `wb_addr` in REG_ADDR_WIDTH, `wb_val` in WORD_WIDTH: writeback, shared with `reg_file` `w_en/rd_addr/rd_val`.
- `flush` in 1: discard the output register and refuse input this cycle.
- `out_valid` out 1, `out_ready` in 1: ID/EX handshake.
- `out_pc`, `out_rs1_val`, `out_rs2_val`, `out_imm` out WORD_WIDTH.
- `out_rd_addr` out REG_ADDR_WIDTH, `out_rd_we` out 1.
- `out_opcode` out 7, `out_funct3` out 3, `out_funct7b5` out 1.
- `out_illegal` out 1: opcode not in the decoded set.

## Operation
- Opcode classes:
  - R `0110011`.
  - I `0010011`/`0000011`/`1100111`.
  - S `0100011`.
  - B `1100011`.
  - U `0110111`/`0010111`.
  - J `1101111`.
  - Any other opcode sets `out_illegal=1`, `rd_we=0`, imm=0, no sources used.
- Immediates are standard RV32I sign-extended forms. R-type imm=0.
- uses_rs1: R, I, S, B. uses_rs2: R, S, B. rd_we: R, I, U, J, and only when rd≠0.
- Source register x0 never hazards.
- Hazard on source `r` (used, r≠0) exists if either:
  - `sb[r]` is set, or
  - `out_valid && out_rd_we && out_rd_addr==r`.
- WAW hazard: same test applied to the incoming rd when rd_we.
- `in_ready = !rst && !flush && (!out_valid || out_ready) && !hazard`.
- Accept (`in_valid && in_ready`): load the output register with decoded fields and operand values. Set `out_valid=1`.
- Issue (`out_valid && out_ready && !flush`):
  - Set `sb[out_rd_addr]` if `out_rd_we`.
  - Clear `out_valid` unless a new accept happens in the same cycle.
- Writeback (`wb_en && wb_addr≠0`): clear `sb[wb_addr]`.
  - Same-cycle set and clear of the same bit: set wins. A new writer issued, and WAW stalling guarantees the clear belonged to an older write.
- Flush: `out_valid←0` next cycle and no scoreboard set for the discarded entry. Scoreboard bits already set are retained, because their owners still write back.
- Downstream contract: every issued `rd_we` instruction eventually produces exactly one writeback.

## Timing
- Latency: accept in cycle N, so `out_*` is valid in N+1.
- Throughput: 1 per cycle without hazards.
- Output register holds stable while `out_valid && !out_ready`.
- RAW on an issued producer: the consumer stalls until the scoreboard bit clears. The bit clears the cycle after `wb_en`; in that cycle `reg_file` already holds the new value.
- Reset: `out_valid=0`; all `out_*` data = 0; scoreboard all 0; `in_ready=0` during `rst`.
- Reset mid-stall or mid-transfer discards everything; no writebacks are expected afterwards.

## Configuration
- `ID_WB_FORWARD_EN` defined:
  - A source hazard caused only by `sb[r]` is waived when `wb_en && wb_addr==r` in the same cycle.
  - The captured operand is then `wb_val`, not the stale `rs*_val`.
  - This saves one stall cycle per writeback dependency.
  - WAW and output-register hazards are unaffected.
- Not defined: no bypass; the consumer is accepted the cycle after `wb_en`.

## Test plan
- **Straight-line issue:** `addi x1,x0,5` then `addi x2,x0,7`, out_ready=1 → out_imm 5 then 7, out_rd_addr 1 then 2, one per cycle.
- **RAW stall:** `addi x1,x0,5` issues, then `add x3,x1,x1`.
  - in_ready stays 0 until writeback `wb_en=1,wb_addr=1,wb_val=5`.
  - Without macro: accepted the next cycle with out_rs1_val=5.
  - With macro: accepted in the wb cycle with 5.
- **x0:** `add x5,x0,x0` with `sb` empty, plus `addi x0,x0,1` → no stall; the x0 write leaves `out_rd_we=0` and the scoreboard unchanged.
- **Backpressure:** out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* held; on out_ready=1 the next instruction appears one cycle later.
- **Flush:** flush asserted with out_valid=1 and `lui x4,0x12345` in the output register → out_valid=0 next cycle, `sb[4]` stays 0, and a following `add x6,x4,x0` is accepted without stall.
- **Set/clear collision:** issue `addi x7,...` in the same cycle as `wb_en` for x7 from the prior writer → `sb[7]` remains 1, and the dependent instruction waits for the second writeback.
